// File: rtl/hazard_interlock_unit_pkg.sv
// hazard_interlock_unit_pkg
//   Shared constants and types for the decode-stage hazard interlock.
//   ForwardingUnit uses the same register-file constants.
//   Contents:
//     NREG, AW          register file size and register address width
//     LOAD_LAT, MUL_LAT result latencies, in cycles from issue
//     CW                countdown width; must hold MUL_LAT-1
//     idClass_e         instruction class encoding used in decode
//     issueCountdown()  countdown value loaded into a register slot on issue
package hazard_interlock_unit_pkg;

  localparam int NREG     = 16;
  localparam int AW       = 4;
  localparam int LOAD_LAT = 2;
  localparam int MUL_LAT  = 4;
  localparam int CW       = 3;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_RSVD = 2'b11
  } idClass_e;

  // An ALU result is forwardable from EM on the next cycle, so it needs no
  // stall. The reserved class behaves like ALU.
  function automatic logic [CW-1:0] issueCountdown(input logic [1:0] cls);
    logic [CW-1:0] val;
    case (cls)
      CLS_LOAD: val = CW'(LOAD_LAT - 1);
      CLS_MUL:  val = CW'(MUL_LAT - 1);
      default:  val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/hazard_interlock_unit_if.sv
// hazard_interlock_unit_if
//   Decode-side bus between the ID stage and the hazard interlock.
//   Signals:
//     ID_Valid, ID_OP1, ID_OP2, ID_Use1, ID_Use2,
//     ID_RD, ID_RegWrite, ID_Class   instruction currently held in ID
//     MWB_RD, MWB_RegWrite           writeback commit
//     Flush                          squash the ID instruction this cycle
//     Stall, Issue, Pending          interlock decisions and producer status
//   Modports:
//     master  decode / pipeline control side
//     slave   the interlock unit
interface hazard_interlock_unit_if;
  import hazard_interlock_unit_pkg::*;

  logic            ID_Valid;
  logic [AW-1:0]   ID_OP1;
  logic [AW-1:0]   ID_OP2;
  logic            ID_Use1;
  logic            ID_Use2;
  logic [AW-1:0]   ID_RD;
  logic            ID_RegWrite;
  logic [1:0]      ID_Class;
  logic [AW-1:0]   MWB_RD;
  logic            MWB_RegWrite;
  logic            Flush;
  logic            Stall;
  logic            Issue;
  logic [NREG-1:0] Pending;

  modport master (
    output ID_Valid, ID_OP1, ID_OP2, ID_Use1, ID_Use2, ID_RD, ID_RegWrite,
           ID_Class, MWB_RD, MWB_RegWrite, Flush,
    input  Stall, Issue, Pending
  );

  modport slave (
    input  ID_Valid, ID_OP1, ID_OP2, ID_Use1, ID_Use2, ID_RD, ID_RegWrite,
           ID_Class, MWB_RD, MWB_RegWrite, Flush,
    output Stall, Issue, Pending
  );

endinterface

// File: rtl/hazard_interlock_unit_slot.sv
// hazard_reg_slot
//   Tracking state for one architectural register: the remaining stall
//   countdown for consumers and the pending-writeback flag.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     setEn     an issuing instruction writes this register
//     setVal    countdown value to load on setEn
//     clrEn     writeback is committing this register
//     cnt       current countdown (0 = operand reachable via bypass)
//     pend      register has an issued, not-yet-written-back producer
module hazard_reg_slot
  import hazard_interlock_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          setEn,
  input  logic [CW-1:0] setVal,
  input  logic          clrEn,
  output logic [CW-1:0] cnt,
  output logic          pend
);

  logic [CW-1:0] cntReg;
  logic          pendReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cntReg  <= '0;
      pendReg <= 1'b0;
    end else begin
      // A new producer overrides whatever countdown is still running.
      if (setEn)
        cntReg <= setVal;
      else if (cntReg != '0)
        cntReg <= cntReg - 1'b1;

      // The newer producer wins over a writeback of the older one.
      if (setEn)
        pendReg <= 1'b1;
      else if (clrEn)
        pendReg <= 1'b0;
    end
  end

  assign cnt  = cntReg;
  assign pend = pendReg;

endmodule

// File: rtl/hazard_interlock_unit.sv
// hazard_interlock_unit
//   Decode-stage interlock: decides whether the instruction in ID can issue
//   or has to wait until its operands are reachable through the EM/MWB
//   bypass, and whether the non-pipelined multiplier is free.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous reset, active-high
//     bus   hazard_interlock_unit_if.slave
//             in : ID_* instruction fields, MWB_RD/MWB_RegWrite, Flush
//             out: Stall (hold PC and IF/ID, bubble ID/EX),
//                  Issue (ID instruction enters EX),
//                  Pending (per-register in-flight producer flags)
module hazard_interlock_unit
  import hazard_interlock_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  hazard_interlock_unit_if.slave bus
);

  logic [CW-1:0]   cntArr [NREG];
  logic [NREG-1:0] pendVec;
  logic [CW-1:0]   mulBusyReg;
  logic [CW-1:0]   setVal;
  logic            issueWrite;
  logic            isMul;
  logic            raw;
  logic            waw;
  logic            struc;
  logic            live;
  logic            stall;
  logic            issue;

  assign setVal     = issueCountdown(bus.ID_Class);
  assign isMul      = (bus.ID_Class == CLS_MUL);
  assign issueWrite = issue & bus.ID_RegWrite;

  for (genvar gi = 0; gi < NREG; gi++) begin : gSlot
    hazard_reg_slot uSlot (
      .clk    (clk),
      .rst    (rst),
      .setEn  (issueWrite & (bus.ID_RD == AW'(gi))),
      .setVal (setVal),
      .clrEn  (bus.MWB_RegWrite & (bus.MWB_RD == AW'(gi))),
      .cnt    (cntArr[gi]),
      .pend   (pendVec[gi])
    );
  end

  // All checks read the pre-issue countdowns, so an instruction that both
  // reads and writes the same register is judged against the older producer.
  // OP1 and OP2 naming the same register just OR into one stall condition.
  assign raw   = (bus.ID_Use1 & (cntArr[bus.ID_OP1] != '0)) |
                 (bus.ID_Use2 & (cntArr[bus.ID_OP2] != '0));
  assign waw   = bus.ID_RegWrite & (cntArr[bus.ID_RD] != '0);
  assign struc = isMul & (mulBusyReg != '0);

  // A flushed or reset cycle neither stalls nor issues.
  assign live  = bus.ID_Valid & ~bus.Flush & ~rst;
  assign stall = live & (raw | waw | struc);
  assign issue = live & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      mulBusyReg <= '0;
    end else if (issue & isMul) begin
      mulBusyReg <= CW'(MUL_LAT - 1);
    end else if (mulBusyReg != '0) begin
      mulBusyReg <= mulBusyReg - 1'b1;
    end
  end

  assign bus.Stall   = stall;
  assign bus.Issue   = issue;
  assign bus.Pending = pendVec;

endmodule

// File: tb/tb_hazard_interlock_unit.sv
module tb_hazard_interlock_unit;
  import hazard_interlock_unit_pkg::*;

  typedef struct {
    string           name;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] pend;
    bit              chkPend;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   driveDone = 1'b0;
  exp_t expQ[$];

  hazard_interlock_unit_if bus();

  hazard_interlock_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; inputs change 1 time unit after the rising edge
  // and the expected response for that cycle is queued for the monitor.
  task automatic step(input string name, input logic r, input logic v,
                      input int op1, input int op2, input logic u1, input logic u2,
                      input int rd, input logic rw, input logic [1:0] cls,
                      input int mRd, input logic mRw, input logic fl,
                      input logic eStall, input logic eIssue,
                      input logic [NREG-1:0] ePend, input bit chkP);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ID_Valid     = v;
    bus.ID_OP1       = AW'(op1);
    bus.ID_OP2       = AW'(op2);
    bus.ID_Use1      = u1;
    bus.ID_Use2      = u2;
    bus.ID_RD        = AW'(rd);
    bus.ID_RegWrite  = rw;
    bus.ID_Class     = cls;
    bus.MWB_RD       = AW'(mRd);
    bus.MWB_RegWrite = mRw;
    bus.Flush        = fl;
    e.name    = name;
    e.stall   = eStall;
    e.issue   = eIssue;
    e.pend    = ePend;
    e.chkPend = chkP;
    expQ.push_back(e);
  endtask

  // Monitor: the DUT presents a decision every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checks++;
        if (bus.Stall !== e.stall) begin
          errors++;
          $display("FAIL %s.stall got=%b want=%b", e.name, bus.Stall, e.stall);
        end
        checks++;
        if (bus.Issue !== e.issue) begin
          errors++;
          $display("FAIL %s.issue got=%b want=%b", e.name, bus.Issue, e.issue);
        end
        if (e.chkPend) begin
          checks++;
          if (bus.Pending !== e.pend) begin
            errors++;
            $display("FAIL %s.pending got=%h want=%h", e.name, bus.Pending, e.pend);
          end
        end
        $display("txn %-12s stall=%b issue=%b pending=%h", e.name, bus.Stall,
                 bus.Issue, bus.Pending);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1, "timeout");
  end

  localparam logic [1:0] ALU  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] MUL  = 2'b10;

  initial begin
    rst = 1'b1;
    bus.ID_Valid = 1'b0; bus.ID_OP1 = '0; bus.ID_OP2 = '0; bus.ID_Use1 = 1'b0;
    bus.ID_Use2 = 1'b0; bus.ID_RD = '0; bus.ID_RegWrite = 1'b0; bus.ID_Class = ALU;
    bus.MWB_RD = '0; bus.MWB_RegWrite = 1'b0; bus.Flush = 1'b0;

    //    name          rst v  op1 op2 u1 u2 rd rw cls   mRd mRw fl  St Is pend      chkP
    // reset with a valid instruction in ID
    step("rst0",        1, 1,  0,  0, 0, 0, 3, 1, MUL,   0, 0, 0,  0, 0, 16'h0000, 0);
    step("rst1",        1, 1,  0,  0, 0, 0, 3, 1, MUL,   0, 0, 0,  0, 0, 16'h0000, 1);
    step("idle",        0, 0,  0,  0, 0, 0, 0, 0, ALU,   0, 0, 0,  0, 0, 16'h0000, 1);
    // load-use: one bubble
    step("ld12",        0, 1,  0,  0, 0, 0, 12, 1, LOAD, 0, 0, 0,  0, 1, 16'h0000, 1);
    step("use12_st",    0, 1, 12,  0, 1, 0, 1, 1, ALU,   0, 0, 0,  1, 0, 16'h1000, 1);
    step("use12_go",    0, 1, 12,  0, 1, 0, 1, 1, ALU,   0, 0, 0,  0, 1, 16'h1000, 1);
    step("wb12",        0, 0,  0,  0, 0, 0, 0, 0, ALU,  12, 1, 0,  0, 0, 16'h1002, 1);
    step("wb1",         0, 0,  0,  0, 0, 0, 0, 0, ALU,   1, 1, 0,  0, 0, 16'h0002, 1);
    // ALU producer is forwarded, no stall
    step("alu13",       0, 1,  0,  0, 0, 0, 13, 1, ALU,  0, 0, 0,  0, 1, 16'h0000, 1);
    step("use13",       0, 1,  0, 13, 0, 1, 0, 0, ALU,   0, 0, 0,  0, 1, 16'h2000, 1);
    step("wb13",        0, 0,  0,  0, 0, 0, 0, 0, ALU,  13, 1, 0,  0, 0, 16'h2000, 1);
    step("clr13",       0, 0,  0,  0, 0, 0, 0, 0, ALU,   0, 0, 0,  0, 0, 16'h0000, 1);
    // back-to-back MUL: structural stall for three cycles
    step("mul5",        0, 1,  2,  0, 1, 0, 5, 1, MUL,   0, 0, 0,  0, 1, 16'h0000, 1);
    step("mul6_s1",     0, 1,  1,  0, 1, 0, 6, 1, MUL,   0, 0, 0,  1, 0, 16'h0020, 1);
    step("mul6_s2",     0, 1,  1,  0, 1, 0, 6, 1, MUL,   0, 0, 0,  1, 0, 16'h0020, 1);
    step("mul6_s3",     0, 1,  1,  0, 1, 0, 6, 1, MUL,   0, 0, 0,  1, 0, 16'h0020, 1);
    step("mul6_go",     0, 1,  1,  0, 1, 0, 6, 1, MUL,   0, 0, 0,  0, 1, 16'h0020, 1);
    // OP1==OP2==RD on a busy register, flush in the middle
    step("dup6_st",     0, 1,  6,  6, 1, 1, 6, 1, ALU,   0, 0, 0,  1, 0, 16'h0060, 1);
    step("dup6_fl",     0, 1,  6,  6, 1, 1, 6, 1, ALU,   0, 0, 1,  0, 0, 16'h0060, 1);
    step("dup6_st2",    0, 1,  6,  6, 1, 1, 6, 1, ALU,   0, 0, 0,  1, 0, 16'h0060, 1);
    step("dup6_go",     0, 1,  6,  6, 1, 1, 6, 1, ALU,   0, 0, 0,  0, 1, 16'h0060, 1);
    // flush during a load-use stall: countdown keeps running
    step("ld12b",       0, 1,  0,  0, 0, 0, 12, 1, LOAD, 0, 0, 0,  0, 1, 16'h0060, 1);
    step("use12_fl",    0, 1, 12,  0, 1, 0, 0, 0, ALU,   0, 0, 1,  0, 0, 16'h1060, 1);
    step("use12_nost",  0, 1, 12,  0, 1, 0, 0, 0, ALU,   0, 0, 0,  0, 1, 16'h1060, 1);
    // set and clear of pend on the same register: set wins
    step("alu7_wb7",    0, 1,  0,  0, 0, 0, 7, 1, ALU,   7, 1, 0,  0, 1, 16'h1060, 1);
    step("wb12b",       0, 0,  0,  0, 0, 0, 0, 0, ALU,  12, 1, 0,  0, 0, 16'h10e0, 1);
    step("chk7",        0, 0,  0,  0, 0, 0, 0, 0, ALU,   0, 0, 0,  0, 0, 16'h00e0, 1);
    // reset in the middle of a MUL stall
    step("mul9",        0, 1,  0,  0, 0, 0, 9, 1, MUL,   0, 0, 0,  0, 1, 16'h00e0, 1);
    step("mul10_st",    0, 1,  0,  0, 0, 0, 10, 1, MUL,  0, 0, 0,  1, 0, 16'h02e0, 1);
    step("mul10_rst",   1, 1,  0,  0, 0, 0, 10, 1, MUL,  0, 0, 0,  0, 0, 16'h02e0, 1);
    step("mul10_go",    0, 1,  0,  0, 0, 0, 10, 1, MUL,  0, 0, 0,  0, 1, 16'h0000, 1);
    step("chk10",       0, 0,  0,  0, 0, 0, 0, 0, ALU,   0, 0, 0,  0, 0, 16'h0400, 1);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 queued", expQ.size());
    end
    driveDone = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
